// File: rtl/pull_word_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pull_word_buffer
//  Description : Four-phase push channel in, DEPTH-entry FIFO, four-phase pull
//                channel out. Feeds the 18-bit pull input of a word slicer.
//                Optional macro PULL_DATA_RTZ_EN: out_0d returns to zero
//                whenever out_0a is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pull_word_buffer #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inp_0r,
    output logic                         inp_0a,
    input  logic [WIDTH-1:0]             inp_0d,
    input  logic                         out_0r,
    output logic                         out_0a,
    output logic [WIDTH-1:0]             out_0d,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] C_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] C_PTR1 = PTR_W'(1);

    typedef enum logic [0:0] {P_IDLE = 1'b0, P_ACK = 1'b1} push_state_t;
    typedef enum logic [0:0] {Q_IDLE = 1'b0, Q_ACK = 1'b1} pull_state_t;

    push_state_t            push_state_q, push_state_d;
    pull_state_t            pull_state_q, pull_state_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_q, wr_d;
    logic [PTR_W-1:0]       rd_q, rd_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [WIDTH-1:0]       out_0d_q, out_0d_d;
    logic                   push_fire;
    logic                   pop_fire;

    // Push side: accept one word per four-phase cycle while space remains.
    always_comb begin
        push_state_d = push_state_q;
        push_fire    = 1'b0;
        wr_d         = wr_q;
        mem_d        = mem_q;
        case (push_state_q)
            P_IDLE: begin
                if (inp_0r && (level_q != C_FULL)) begin
                    push_fire     = 1'b1;
                    mem_d[wr_q]   = inp_0d;
                    wr_d          = wr_q + C_PTR1;
                    push_state_d  = P_ACK;
                end
            end
            P_ACK: begin
                if (!inp_0r) begin
                    push_state_d = P_IDLE;
                end
            end
            default: push_state_d = P_IDLE;
        endcase
    end

    // Pull side: pop the oldest word into the output register on request.
    always_comb begin
        pull_state_d = pull_state_q;
        pop_fire     = 1'b0;
        rd_d         = rd_q;
        out_0d_d     = out_0d_q;
        case (pull_state_q)
            Q_IDLE: begin
                if (out_0r && (level_q != '0)) begin
                    pop_fire     = 1'b1;
                    out_0d_d     = mem_q[rd_q];
                    rd_d         = rd_q + C_PTR1;
                    pull_state_d = Q_ACK;
                end
            end
            Q_ACK: begin
                if (!out_0r) begin
                    pull_state_d = Q_IDLE;
`ifdef PULL_DATA_RTZ_EN
                    // Data returns to zero on the same edge the acknowledge drops.
                    out_0d_d     = '0;
`endif
                end
            end
            default: pull_state_d = Q_IDLE;
        endcase
    end

    // Occupancy follows the registered fire decisions; a push and pop together cancel.
    always_comb begin
        level_d = level_q;
        case ({push_fire, pop_fire})
            2'b10:   level_d = level_q + C_ONE;
            2'b01:   level_d = level_q - C_ONE;
            default: level_d = level_q;
        endcase
    end

    // State, pointer, storage and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_state_q <= P_IDLE;
            pull_state_q <= Q_IDLE;
            wr_q         <= '0;
            rd_q         <= '0;
            level_q      <= '0;
            out_0d_q     <= '0;
            mem_q        <= '{default: '0};
        end else begin
            push_state_q <= push_state_d;
            pull_state_q <= pull_state_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            level_q      <= level_d;
            out_0d_q     <= out_0d_d;
            mem_q        <= mem_d;
        end
    end

    assign inp_0a = (push_state_q == P_ACK);
    assign out_0a = (pull_state_q == Q_ACK);
    assign out_0d = out_0d_q;
    assign level  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_pull_word_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pull_word_buffer
//  Description : Directed self-checking bench for pull_word_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pull_word_buffer;

`ifdef PULL_DATA_RTZ_EN
    localparam bit RTZ = 1'b1;
`else
    localparam bit RTZ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        inp_0r;
    logic        inp_0a;
    logic [17:0] inp_0d;
    logic        out_0r;
    logic        out_0a;
    logic [17:0] out_0d;
    logic [1:0]  level;

    int n_pass;
    int n_total;
    int lvl_bad;
    logic [17:0] got_words [8];
    logic [17:0] w;

    pull_word_buffer #(.WIDTH(18), .DEPTH(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .inp_0r (inp_0r),
        .inp_0a (inp_0a),
        .inp_0d (inp_0d),
        .out_0r (out_0r),
        .out_0a (out_0a),
        .out_0d (out_0d),
        .level  (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [17:0] d);
        int n;
        inp_0d = d;
        inp_0r = 1'b1;
        n = 0;
        while (inp_0a !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) check("push_ack_timeout", 32'd0, 32'd1);
        inp_0r = 1'b0;
        n = 0;
        while (inp_0a !== 1'b0 && n < 20) begin tick(); n++; end
        if (n >= 20) check("push_rel_timeout", 32'd0, 32'd1);
    endtask

    task automatic pull_word(output logic [17:0] d);
        int n;
        out_0r = 1'b1;
        n = 0;
        d = '0;
        while (out_0a !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) check("pull_ack_timeout", 32'd0, 32'd1);
        d = out_0d;
        out_0r = 1'b0;
        n = 0;
        while (out_0a !== 1'b0 && n < 20) begin tick(); n++; end
        if (n >= 20) check("pull_rel_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_pass = 0; n_total = 0; lvl_bad = 0;
        rst = 1'b1; inp_0r = 1'b0; inp_0d = '0; out_0r = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_inp_0a", inp_0a, 0);
        check("rst_out_0a", out_0a, 0);
        check("rst_out_0d", out_0d, 0);
        check("rst_level",  level,  0);

        // Pull on empty stalls.
        out_0r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_stall_out_0a", out_0a, 0);
        end
        out_0r = 1'b0;
        tick();

        // Single word round trip with one-cycle latency.
        inp_0d = 18'h2AAAA; inp_0r = 1'b1;
        tick();
        check("push1_ack", inp_0a, 1);
        check("push1_level", level, 1);
        inp_0r = 1'b0;
        tick();
        check("push1_rel", inp_0a, 0);
        out_0r = 1'b1;
        tick();
        check("pull1_ack", out_0a, 1);
        check("pull1_data", out_0d, 18'h2AAAA);
        check("pull1_level", level, 0);
        out_0r = 1'b0;
        tick();
        check("pull1_rel", out_0a, 0);
        check("pull1_data_after", out_0d, RTZ ? 18'h0 : 18'h2AAAA);

        // Fill, stall a third push, release it with one pop.
        push_word(18'h00001);
        push_word(18'h3FFFF);
        check("full_level", level, 2);
        inp_0d = 18'h12345; inp_0r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_stall_inp_0a", inp_0a, 0);
        end
        out_0r = 1'b1;
        tick();
        check("full_pop_ack", out_0a, 1);
        check("full_pop_data", out_0d, 18'h00001);
        check("full_pop_push_still_stalled", inp_0a, 0);
        check("full_pop_level", level, 1);
        tick();
        check("full_late_push_ack", inp_0a, 1);
        check("full_late_level", level, 2);
        check("full_pop_data_stable", out_0d, 18'h00001);
        inp_0r = 1'b0; out_0r = 1'b0;
        tick();
        check("full_rel_inp", inp_0a, 0);
        check("full_rel_out", out_0a, 0);
        pull_word(w);
        check("full_pull2", w, 18'h3FFFF);
        pull_word(w);
        check("full_pull3", w, 18'h12345);
        check("full_drained_level", level, 0);

        // Overlapping stream of eight words through the two-entry FIFO.
        fork
            begin
                for (int i = 0; i < 8; i++) push_word(18'h00010 + 18'(i));
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    logic [17:0] r;
                    pull_word(r);
                    got_words[j] = r;
                    if (j % 3 == 0) tick();
                end
            end
            begin
                repeat (80) begin
                    tick();
                    if (level > 2'd2) lvl_bad++;
                end
            end
        join
        for (int i = 0; i < 8; i++)
            check("stream_word", {14'd0, got_words[i]}, 32'h10 + i);
        check("stream_level_bound", lvl_bad, 0);
        check("stream_level_end", level, 0);

        // Reset in the middle of both handshakes.
        push_word(18'h0AAAA);
        inp_0d = 18'h05555; inp_0r = 1'b1; out_0r = 1'b1;
        tick();
        check("mid_inp_0a", inp_0a, 1);
        check("mid_out_0a", out_0a, 1);
        check("mid_level", level, 1);
        check("mid_out_0d", out_0d, 18'h0AAAA);
        rst = 1'b1;
        tick();
        rst = 1'b0; inp_0r = 1'b0;
        check("mid_rst_inp_0a", inp_0a, 0);
        check("mid_rst_out_0a", out_0a, 0);
        check("mid_rst_out_0d", out_0d, 0);
        check("mid_rst_level", level, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_stall", out_0a, 0);
        end
        out_0r = 1'b0;
        tick();

        // Data behaviour after acknowledge falls.
        push_word(18'h15555);
        out_0r = 1'b1;
        tick();
        check("rtz_ack", out_0a, 1);
        check("rtz_data_valid", out_0d, 18'h15555);
        out_0r = 1'b0;
        tick();
        check("rtz_rel", out_0a, 0);
        check("rtz_data_after", out_0d, RTZ ? 18'h0 : 18'h15555);
        tick();
        check("rtz_data_later", out_0d, RTZ ? 18'h0 : 18'h15555);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pull_word_buffer.md
Name: pull_word_buffer

Overview:
- Clocked source stage that feeds a word-slicing handshake component on its 18-bit pull input channel.
- Accepts words on a four-phase push channel, holds up to DEPTH of them in a FIFO, and serves them in order on a four-phase pull channel.
- Decouples the producer's timing from the slicer's request timing.
- All handshake inputs are synchronous to clk.

Parameters:
- WIDTH, 18, data width of both channels.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- inp_0r  input  1  push request from producer; inp_0d is valid while high.
- inp_0a  output  1  push acknowledge.
- inp_0d  input  WIDTH  push data.
- out_0r  input  1  pull request from the consumer (slicer).
- out_0a  output  1  pull acknowledge; out_0d is valid while high.
- out_0d  output  WIDTH  pull data.
- level  output  $clog2(DEPTH+1)  number of words currently stored.

Behaviour:
- Reset (rst high at a clk edge):
  - inp_0a=0, out_0a=0, out_0d=0, level=0.
  - Read and write pointers go to 0; both FSMs go to IDLE.
  - Reset overrides all other activity, including a handshake that is mid-phase. Stored words are discarded.
- Push FSM, states P_IDLE and P_ACK:
  - In P_IDLE, if inp_0r=1 and level<DEPTH: write inp_0d to mem[wr], wr<=wr+1 (wraps mod DEPTH), inp_0a<=1, go to P_ACK.
  - In P_IDLE, if inp_0r=1 and level=DEPTH: stall. inp_0a stays 0 and there is no write.
  - In P_ACK: hold inp_0a=1 until inp_0r=0 is sampled, then inp_0a<=0 and go to P_IDLE.
  - A new push can be accepted no earlier than the edge after inp_0a falls.
- Pull FSM, states Q_IDLE and Q_ACK:
  - In Q_IDLE, if out_0r=1 and level>0: out_0d<=mem[rd], rd<=rd+1 (wraps mod DEPTH), out_0a<=1, go to Q_ACK.
  - In Q_IDLE, if out_0r=1 and level=0: stall with out_0a=0.
  - In Q_ACK: hold out_0a=1 and out_0d stable until out_0r=0 is sampled, then out_0a<=0 and go to Q_IDLE.
- Latency:
  - A request sampled high at edge k with resources available is acknowledged by the registered output after edge k (one cycle).
  - Release is also one cycle.
  - Minimum full handshake is 2 clk cycles per word on each side.
- Level accounting: level<=level+push_fire-pop_fire.
  - A simultaneous push and pop leaves level unchanged.
  - level never exceeds DEPTH and never underflows.
- Boundary decisions use the registered level (no bypass):
  - If empty with a push and a pull request in the same cycle: the push is accepted, and the pull is served at the next edge.
  - If full with a pop and a push request in the same cycle: the pop proceeds, and the push is accepted at the next edge.
- Word order is strictly FIFO. Pointer wrap-around is seamless.
- The out_0d register changes only at a pop, or at reset.

Optional Feature:
- Macro: PULL_DATA_RTZ_EN.
- Defined: out_0d is forced to 0 whenever out_0a=0. It is loaded with the word at pop and returns to 0 at the same edge at which out_0a falls (return-to-zero data).
- Undefined: out_0d holds the last popped word indefinitely, as described in Behaviour.
- Handshake timing, level and ordering are identical in both builds.

Test Plan:
- Reset then idle -> inp_0a=0, out_0a=0, out_0d=0, level=0. out_0r=1 held for 5 cycles on empty -> out_0a stays 0.
- Push 0x2AAAA -> inp_0a rises 1 cycle after inp_0r and level=1. Then pull -> out_0a rises 1 cycle after out_0r with out_0d=0x2AAAA, and level=0.
- Push 0x00001 and 0x3FFFF (level=2), then attempt a third push 0x12345 -> inp_0a stays 0. Complete one pull (0x00001) -> the third push is acknowledged the following cycle. Remaining pulls return 0x3FFFF then 0x12345.
- Stream 8 words 0x00010..0x00017 with overlapping push/pull handshakes (pointer wrap ×4) -> output order matches exactly and level stays within 0..2.
- Assert rst while inp_0a=1 and out_0a=1 with level=1 -> after the edge, all outputs return to 0 and level=0. A subsequent pull on empty stalls.
- With PULL_DATA_RTZ_EN: pull 0x15555 -> out_0d=0x15555 while out_0a=1, and out_0d=0 from the edge at which out_0a falls.
